// File: rtl/system_pkg.sv
// Shared AHB-Lite types and constants for the SoC fabric and its slaves.
package system_pkg;

    localparam int unsigned AHB_ADDR_WIDTH = 32;
    localparam int unsigned AHB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        SLV_IDLE = 3'd0,
        SLV_WAIT = 3'd1,
        SLV_DATA = 3'd2,
        SLV_ERR1 = 3'd3,
        SLV_ERR2 = 3'd4
    } ahbl_slv_state_e;

    // Byte lanes touched by a transfer; sizes above a word collapse to a full word.
    function automatic logic [3:0] be_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << addr_lo;
            HSIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahbl_sram_array.sv
// Word-organised SRAM with per-byte write enables and an asynchronous read port.
module ahbl_sram_array #(
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic                         clk,
    input  logic [3:0]                   i_we,
    input  logic [$clog2(MEM_WORDS)-1:0] i_waddr,
    input  logic [31:0]                  i_wdata,
    input  logic [$clog2(MEM_WORDS)-1:0] i_raddr,
    output logic [31:0]                  o_rdata
);

    logic [31:0] r_mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahblite_sram_slave.sv
// AHB-Lite SRAM responder with configurable wait states and write-to-read forwarding.
// Define AHBL_SRAM_ERR_EN to answer misaligned/out-of-range transfers with ERROR.
module ahblite_sram_slave
    import system_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = AHB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = AHB_DATA_WIDTH,
    parameter int unsigned MEM_WORDS   = 4096,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic                  hmastlock,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hready,
    output logic                  hresp
);

    localparam int unsigned IW = $clog2(MEM_WORDS);

    ahbl_slv_state_e r_state, w_state_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic [IW-1:0]         r_widx;
    logic                  r_write;
    logic [3:0]            r_mask;
    logic [DATA_WIDTH-1:0] r_hrdata, w_hrdata_nxt;

    htrans_e               w_trans;
    logic                  w_accept;
    logic                  w_bad;
    logic                  w_load;
    logic                  w_next_write;
    logic [IW-1:0]         w_idx;
    logic [IW-1:0]         w_rd_idx;
    logic [3:0]            w_mask;
    logic [3:0]            w_mem_we;
    logic [31:0]           w_mem_rd;
    logic [31:0]           w_fwd;
    logic                  w_fwd_hit;
    logic                  w_unused;

    assign w_unused = ^{hburst, hprot, hmastlock, haddr};

    assign w_trans  = htrans_e'(htrans);
    assign w_accept = hsel && hready && (w_trans == HTRANS_NONSEQ || w_trans == HTRANS_SEQ);
    assign w_idx    = haddr[IW+1:2];
    assign w_mask   = be_mask(hsize, haddr[1:0]);

`ifdef AHBL_SRAM_ERR_EN
    always_comb begin
        w_bad = (haddr >> (IW + 2)) != '0;
        if (hsize == HSIZE_HALF && haddr[0]) begin
            w_bad = 1'b1;
        end
        if (hsize >= HSIZE_WORD && haddr[1:0] != 2'b00) begin
            w_bad = 1'b1;
        end
    end
    assign hresp = (r_state == SLV_ERR1 || r_state == SLV_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
    assign w_bad = 1'b0;
    assign hresp = HRESP_OKAY;
`endif

    assign hready = !(r_state == SLV_WAIT || r_state == SLV_ERR1);
    assign hrdata = r_hrdata;

    // The write lands at the end of its final data-phase cycle.
    assign w_mem_we = (r_state == SLV_DATA && r_write && !rst) ? r_mask : 4'b0000;

    // Out of WAIT the read address is already registered; otherwise it is on the bus.
    assign w_rd_idx  = (r_state == SLV_WAIT) ? r_widx : w_idx;
    assign w_fwd_hit = (r_state == SLV_DATA) && r_write && (r_widx == w_rd_idx);

    ahbl_sram_array #(
        .MEM_WORDS(MEM_WORDS)
    ) u_array (
        .clk    (clk),
        .i_we   (w_mem_we),
        .i_waddr(r_widx),
        .i_wdata(hwdata),
        .i_raddr(w_rd_idx),
        .o_rdata(w_mem_rd)
    );

    always_comb begin
        w_fwd = w_mem_rd;
        if (w_fwd_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (r_mask[b]) begin
                    w_fwd[8*b +: 8] = hwdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_load       = 1'b0;
        w_hrdata_nxt = r_hrdata;
        case (r_state)
            SLV_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = SLV_DATA;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            SLV_ERR1: w_state_nxt = SLV_ERR2;
            default: begin
                w_state_nxt = SLV_IDLE;
                if (w_accept) begin
                    w_load = 1'b1;
                    if (w_bad) begin
                        w_state_nxt = SLV_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_state_nxt = SLV_WAIT;
                        w_cnt_nxt   = 4'(WAIT_STATES);
                    end else begin
                        w_state_nxt = SLV_DATA;
                    end
                end
            end
        endcase
        w_next_write = w_load ? hwrite : r_write;
        if (w_state_nxt == SLV_DATA && !w_next_write) begin
            w_hrdata_nxt = w_fwd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= SLV_IDLE;
            r_cnt    <= 4'd0;
            r_widx   <= '0;
            r_write  <= 1'b0;
            r_mask   <= 4'b0000;
            r_hrdata <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hrdata <= w_hrdata_nxt;
            if (w_load) begin
                r_widx  <= w_idx;
                r_write <= hwrite && !w_bad;
                r_mask  <= w_mask;
            end
        end
    end

endmodule

// File: tb/tb_ahblite_sram_slave.sv
// Directed bench: per-cycle vector table on a zero-wait slave, hand sequences on a 3-wait slave.
module tb_ahblite_sram_slave;
    import system_pkg::*;

    typedef struct {
        logic        hsel;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic        exp_ready;
        logic        exp_resp;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    localparam logic [1:0] TI = 2'd0;
    localparam logic [1:0] TB = 2'd1;
    localparam logic [1:0] TN = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_hsel, a_hwrite, a_hready, a_hresp;
    logic [1:0]  a_htrans;
    logic [2:0]  a_hsize;
    logic [31:0] a_haddr, a_hwdata, a_hrdata;

    logic        b_hsel, b_hwrite, b_hready, b_hresp;
    logic [1:0]  b_htrans;
    logic [2:0]  b_hsize;
    logic [31:0] b_haddr, b_hwdata, b_hrdata;

    logic [2:0]  t_hburst = 3'd0;
    logic [3:0]  t_hprot  = 4'd3;
    logic        t_lock   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ahblite_sram_slave #(
        .MEM_WORDS  (4096),
        .WAIT_STATES(0)
    ) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .hsel     (a_hsel),
        .haddr    (a_haddr),
        .htrans   (a_htrans),
        .hwrite   (a_hwrite),
        .hsize    (a_hsize),
        .hburst   (t_hburst),
        .hprot    (t_hprot),
        .hmastlock(t_lock),
        .hwdata   (a_hwdata),
        .hrdata   (a_hrdata),
        .hready   (a_hready),
        .hresp    (a_hresp)
    );

    ahblite_sram_slave #(
        .MEM_WORDS  (4096),
        .WAIT_STATES(3)
    ) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .hsel     (b_hsel),
        .haddr    (b_haddr),
        .htrans   (b_htrans),
        .hwrite   (b_hwrite),
        .hsize    (b_hsize),
        .hburst   (t_hburst),
        .hprot    (t_hprot),
        .hmastlock(t_lock),
        .hwdata   (b_hwdata),
        .hrdata   (b_hrdata),
        .hready   (b_hready),
        .hresp    (b_hresp)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic addv(input logic hsel, input logic [1:0] htrans, input logic hwrite,
                        input logic [2:0] hsize, input logic [31:0] haddr,
                        input logic [31:0] hwdata, input logic ery, input logic ersp,
                        input logic chk, input logic [31:0] erd);
        vec_t v;
        v.hsel = hsel; v.htrans = htrans; v.hwrite = hwrite; v.hsize = hsize;
        v.haddr = haddr; v.hwdata = hwdata; v.exp_ready = ery; v.exp_resp = ersp;
        v.chk_rd = chk; v.exp_rd = erd;
        vecs.push_back(v);
    endtask

    task automatic drive_b(input logic hsel, input logic [1:0] htrans, input logic hwrite,
                           input logic [31:0] haddr, input logic [31:0] hwdata);
        b_hsel = hsel; b_htrans = htrans; b_hwrite = hwrite;
        b_hsize = HSIZE_WORD; b_haddr = haddr; b_hwdata = hwdata;
    endtask

    // Called just after an edge; returns at the negedge of the first hready-high data cycle.
    task automatic wait_data(input string name, output int lows);
        lows = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b_hready) return;
            lows++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: hready still low after %0d cycles, expected high", name, lows);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;

        a_hsel = 0; a_htrans = TI; a_hwrite = 0; a_hsize = HSIZE_WORD;
        a_haddr = 0; a_hwdata = 0;
        drive_b(0, TI, 0, 0, 0);

        // hsel htrans wr size addr hwdata | rdy resp chk rdata
        addv(1, TN, 1, 3'd2, 32'h10, 32'h0,        1, 0, 0, 32'h0);
        addv(1, TN, 0, 3'd2, 32'h10, 32'hDEADBEEF, 1, 0, 0, 32'h0);
        addv(0, TI, 0, 3'd2, 32'h0,  32'h0,        1, 0, 1, 32'hDEADBEEF);
        addv(1, TN, 1, 3'd2, 32'h10, 32'h0,        1, 0, 0, 32'h0);
        addv(0, TI, 0, 3'd2, 32'h0,  32'h11223344, 1, 0, 0, 32'h0);
        addv(1, TN, 1, 3'd0, 32'h13, 32'h0,        1, 0, 0, 32'h0);
        addv(0, TI, 0, 3'd2, 32'h0,  32'hAA998877, 1, 0, 0, 32'h0);
        addv(1, TN, 0, 3'd2, 32'h10, 32'h0,        1, 0, 0, 32'h0);
        addv(0, TI, 0, 3'd2, 32'h0,  32'h0,        1, 0, 1, 32'hAA223344);
        addv(1, TN, 1, 3'd1, 32'h10, 32'h0,        1, 0, 0, 32'h0);
        addv(0, TI, 0, 3'd2, 32'h0,  32'h99995566, 1, 0, 0, 32'h0);
        addv(1, TN, 0, 3'd2, 32'h10, 32'h0,        1, 0, 0, 32'h0);
        addv(0, TI, 0, 3'd2, 32'h0,  32'h0,        1, 0, 1, 32'hAA225566);
        addv(1, TN, 1, 3'd2, 32'h20, 32'h0,        1, 0, 0, 32'h0);
        addv(1, TN, 0, 3'd2, 32'h20, 32'h12345678, 1, 0, 0, 32'h0);
        addv(0, TI, 0, 3'd2, 32'h0,  32'h0,        1, 0, 1, 32'h12345678);
        addv(1, TB, 1, 3'd2, 32'h10, 32'h0,        1, 0, 0, 32'h0);
        addv(0, TI, 0, 3'd2, 32'h0,  32'hFFFFFFFF, 1, 0, 0, 32'h0);
        addv(0, TN, 1, 3'd2, 32'h10, 32'hFFFFFFFF, 1, 0, 0, 32'h0);
        addv(0, TI, 0, 3'd2, 32'h0,  32'hFFFFFFFF, 1, 0, 0, 32'h0);
        addv(1, TN, 0, 3'd5, 32'h10, 32'h0,        1, 0, 0, 32'h0);
        addv(0, TI, 0, 3'd2, 32'h0,  32'h0,        1, 0, 1, 32'hAA225566);
        addv(1, TN, 1, 3'd2, 32'h00, 32'h0,        1, 0, 0, 32'h0);
        addv(0, TI, 0, 3'd2, 32'h0,  32'hCAFEF00D, 1, 0, 0, 32'h0);
        addv(1, TN, 0, 3'd2, 32'h02, 32'h0,        1, 0, 0, 32'h0);
`ifdef AHBL_SRAM_ERR_EN
        addv(0, TI, 0, 3'd2, 32'h0,  32'h0,        0, 1, 0, 32'h0);
        addv(1, TN, 0, 3'd2, 32'h00, 32'h0,        1, 1, 0, 32'h0);
`else
        addv(1, TN, 0, 3'd2, 32'h00, 32'h0,        1, 0, 1, 32'hCAFEF00D);
`endif
        addv(0, TI, 0, 3'd2, 32'h0,  32'h0,        1, 0, 1, 32'hCAFEF00D);
        addv(1, TN, 0, 3'd2, 32'h4010, 32'h0,      1, 0, 0, 32'h0);
`ifdef AHBL_SRAM_ERR_EN
        addv(0, TI, 0, 3'd2, 32'h0,  32'h0,        0, 1, 0, 32'h0);
        addv(0, TI, 0, 3'd2, 32'h0,  32'h0,        1, 1, 0, 32'h0);
`else
        addv(0, TI, 0, 3'd2, 32'h0,  32'h0,        1, 0, 1, 32'hAA225566);
`endif
        addv(0, TI, 0, 3'd2, 32'h0,  32'h0,        1, 0, 0, 32'h0);

        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset hready0", 32'(a_hready), 32'd1);
        check("reset hresp0", 32'(a_hresp), 32'd0);
        check("reset hrdata0", a_hrdata, 32'h0);
        check("reset hready3", 32'(b_hready), 32'd1);
        check("reset hrdata3", b_hrdata, 32'h0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            a_hsel = vecs[i].hsel; a_htrans = vecs[i].htrans; a_hwrite = vecs[i].hwrite;
            a_hsize = vecs[i].hsize; a_haddr = vecs[i].haddr; a_hwdata = vecs[i].hwdata;
            @(negedge clk);
            check($sformatf("vec%0d hready", i), 32'(a_hready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d hresp", i), 32'(a_hresp), 32'(vecs[i].exp_resp));
            if (vecs[i].chk_rd) begin
                check($sformatf("vec%0d hrdata", i), a_hrdata, vecs[i].exp_rd);
            end
        end

        // Three wait states: write, then two reads held on the bus until accepted.
        @(posedge clk);
        #1 drive_b(1, TN, 1, 32'h40, 32'h0);
        @(negedge clk);
        check("ws3 addr hready", 32'(b_hready), 32'd1);
        @(posedge clk);
        #1 drive_b(1, TN, 0, 32'h40, 32'h0BADCAFE);
        wait_data("ws3 write", lows);
        check("ws3 write lows", 32'(lows), 32'd3);
        check("ws3 write hresp", 32'(b_hresp), 32'd0);
        @(posedge clk);
        #1 drive_b(1, TN, 0, 32'h40, 32'h0);
        wait_data("ws3 read1", lows);
        check("ws3 read1 lows", 32'(lows), 32'd3);
        check("ws3 read1 hrdata", b_hrdata, 32'h0BADCAFE);
        @(posedge clk);
        #1 drive_b(0, TI, 0, 32'h0, 32'h0);
        wait_data("ws3 read2", lows);
        check("ws3 read2 lows", 32'(lows), 32'd3);
        check("ws3 read2 hrdata", b_hrdata, 32'h0BADCAFE);
        @(posedge clk);
        @(negedge clk);
        check("ws3 idle hready", 32'(b_hready), 32'd1);

        // Reset during the wait of a write: nothing reaches the SRAM.
        @(posedge clk);
        #1 drive_b(1, TN, 1, 32'h40, 32'h0);
        @(posedge clk);
        #1 drive_b(0, TI, 0, 32'h0, 32'h11111111);
        @(negedge clk);
        check("ws3 midwait hready", 32'(b_hready), 32'd0);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("ws3 post-rst hready", 32'(b_hready), 32'd1);
        check("ws3 post-rst hresp", 32'(b_hresp), 32'd0);
        check("ws3 post-rst hrdata", b_hrdata, 32'h0);
        @(posedge clk);
        #1 drive_b(1, TN, 0, 32'h40, 32'h0);
        @(posedge clk);
        #1 drive_b(0, TI, 0, 32'h0, 32'h0);
        wait_data("ws3 read3", lows);
        check("ws3 read3 lows", 32'(lows), 32'd3);
        check("ws3 read3 hrdata", b_hrdata, 32'h0BADCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
